// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory arbiter and its clients.
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Byte-lane store masks; store data is low-aligned and shifted to the lowest lane set.
  localparam logic [3:0] WM_SB0   = 4'b0001;
  localparam logic [3:0] WM_SB1   = 4'b0010;
  localparam logic [3:0] WM_SB2   = 4'b0100;
  localparam logic [3:0] WM_SB3   = 4'b1000;
  localparam logic [3:0] WM_SH_LO = 4'b0011;
  localparam logic [3:0] WM_SH_HI = 4'b1100;
  localparam logic [3:0] WM_SW    = 4'b1111;

  // Load masks: [3:0] byte lanes, [4] sign-extend from the top selected lane.
  localparam logic [4:0] RM_LBU0   = 5'b00001;
  localparam logic [4:0] RM_LBU1   = 5'b00010;
  localparam logic [4:0] RM_LBU2   = 5'b00100;
  localparam logic [4:0] RM_LBU3   = 5'b01000;
  localparam logic [4:0] RM_LB0    = 5'b10001;
  localparam logic [4:0] RM_LB1    = 5'b10010;
  localparam logic [4:0] RM_LB2    = 5'b10100;
  localparam logic [4:0] RM_LB3    = 5'b11000;
  localparam logic [4:0] RM_LHU_LO = 5'b00011;
  localparam logic [4:0] RM_LHU_HI = 5'b01100;
  localparam logic [4:0] RM_LH_LO  = 5'b10011;
  localparam logic [4:0] RM_LH_HI  = 5'b11100;
  localparam logic [4:0] RM_LW     = 5'b01111;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  typedef struct packed {
    logic [3:0]        wmem;
    logic [4:0]        rmem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the dmem command/load-data bus.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);
  logic              m0_req, m1_req;
  logic              m0_lock, m1_lock;
  logic [3:0]        m0_wmem, m1_wmem;
  logic [4:0]        m0_rmem, m1_rmem;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [3:0]        wmem;
  logic [4:0]        rmem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_data;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_wmem, m1_wmem, m0_rmem, m1_rmem,
           m0_addr, m1_addr, m0_wdata, m1_wdata, load_data,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           wmem, rmem, mem_addr, store_data
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_wmem, m1_wmem, m0_rmem, m1_rmem,
           m0_addr, m1_addr, m0_wdata, m1_wdata, load_data,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           wmem, rmem, mem_addr, store_data
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin with a bounded lock; one-hot combinational grant.
module rr_arb2 import dmem_pkg::*; #(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  localparam int            CW   = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          hold, win;

  // Pick the winner, then advance lock ownership; cnt counts locked beats including the entry beat.
  always_comb begin
    gnt     = '0;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    hold    = (state_q == LOCKED) && req[owner_q];
    if (hold)        win = owner_q;
    else if (&req)   win = ~last_q;
    else             win = req[1];
    gnt[win] = |req;
    if (|req) begin
      last_d = win;
      if (hold) begin
        if (lock[owner_q] && (cnt_inc < LMAX)) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else if (lock[win] && (LOCK_MAX > 1)) begin
        // LOCK_MAX of 1 means a lock can never extend past its own beat.
        state_d = LOCKED;
        owner_d = win;
        cnt_d   = CW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      // Owner dropping req (with nobody else asking) also ends the lock.
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two ports onto dmem: grant, issue register, tagged response register.
module dmem_arbiter #(
  parameter int ADDR_W   = dmem_pkg::ADDR_W,
  parameter int DATA_W   = dmem_pkg::DATA_W,
  parameter int LOCK_MAX = 8
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  logic [1:0]        req, lock, gnt;
  logic              iss_v_q, iss_v_d, iss_port_q, iss_port_d;
  logic [3:0]        wmem_q, wmem_d;
  logic [4:0]        rmem_q, rmem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_v_q, rsp_v_d, rsp_port_q, rsp_port_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rv0, rv1;

  assign req  = {bus.m1_req, bus.m0_req};
  assign lock = {bus.m1_lock, bus.m0_lock};

  rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .lock  (lock),
    .gnt   (gnt)
  );

  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];

  // Mux the granted port's command into the issue stage; the command holds while idle.
  always_comb begin
    iss_v_d    = |gnt;
    iss_port_d = gnt[1];
    wmem_d     = wmem_q;
    rmem_d     = rmem_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (gnt[1]) begin
      wmem_d  = bus.m1_wmem;
      rmem_d  = bus.m1_rmem;
      addr_d  = bus.m1_addr;
      wdata_d = bus.m1_wdata;
    end else if (gnt[0]) begin
      wmem_d  = bus.m0_wmem;
      rmem_d  = bus.m0_rmem;
      addr_d  = bus.m0_addr;
      wdata_d = bus.m0_wdata;
    end
  end

  // Capture dmem's load result one cycle after issue; stores and no-ops return 0.
  always_comb begin
    rsp_v_d    = iss_v_q;
    rsp_port_d = iss_port_q;
    rdata_d    = (iss_v_q && (rmem_q != '0)) ? bus.load_data : '0;
  end

  // Issue and response registers; async reset drops any in-flight beat at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v_q    <= 1'b0;
      iss_port_q <= 1'b0;
      wmem_q     <= '0;
      rmem_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_v_q    <= 1'b0;
      rsp_port_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      iss_v_q    <= iss_v_d;
      iss_port_q <= iss_port_d;
      wmem_q     <= wmem_d;
      rmem_q     <= rmem_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_v_q    <= rsp_v_d;
      rsp_port_q <= rsp_port_d;
      rdata_q    <= rdata_d;
    end
  end

  // Idle cycles must never write or read, so masks are gated by the issue valid.
  assign bus.wmem       = iss_v_q ? wmem_q : '0;
  assign bus.rmem       = iss_v_q ? rmem_q : '0;
  assign bus.mem_addr   = addr_q;
  assign bus.store_data = wdata_q;

  assign rv0           = rsp_v_q & ~rsp_port_q;
  assign rv1           = rsp_v_q &  rsp_port_q;
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = rv0 ? rdata_q : '0;
  assign bus.m1_rdata  = rv1 ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a reference model and response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LOCK_MAX = 3;

  typedef struct packed {logic lk; dmem_cmd_t c;} beat_t;
  typedef struct {int port; logic [31:0] data; int due;} rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  rsp_t        sbq [$];
  beat_t       pq0 [$], pq1 [$];
  logic [1:0]  g_seen = '0;
  logic [7:0]  g1_hist = '0;
  logic [31:0] last_rd [2];
  int          rv_cnt  [2];
  // reference arbitration state: last winner and the current lock run
  int          m_last = 1, m_owner = 0, m_run = 0;
  bit          m_active = 1'b0;

  function automatic logic [31:0] do_load(input logic [31:0] w, input logic [4:0] rm);
    int lo = 0, hi = 0, nb;
    logic [31:0] v, m;
    if (rm[3:0] == 4'd0) return 32'd0;
    for (int i = 3; i >= 0; i--) if (rm[i]) lo = i;
    for (int i = 0; i < 4; i++) if (rm[i]) hi = i;
    nb = hi - lo + 1;
    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = (w >> (8 * lo)) & m;
    if (rm[4] && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] do_store(input logic [31:0] w, input logic [3:0] wm, input logic [31:0] wd);
    int lo = 0;
    logic [31:0] s, r;
    for (int i = 3; i >= 0; i--) if (wm[i]) lo = i;
    s = wd << (8 * lo);
    r = w;
    for (int i = 0; i < 4; i++) if (wm[i]) r[8*i +: 8] = s[8*i +: 8];
    return r;
  endfunction

  // dmem model: combinational load, store commits on the clock edge
  assign bus.load_data = do_load(mem[bus.mem_addr[5:0]], bus.rmem);
  always @(posedge clk) if (bus.wmem != 4'd0) mem[bus.mem_addr[5:0]] <= do_store(mem[bus.mem_addr[5:0]], bus.wmem, bus.store_data);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input logic lk, input logic [3:0] wm, input logic [4:0] rm,
                               input logic [31:0] a, input logic [31:0] wd);
    beat_t b;
    b.lk = lk; b.c.wmem = wm; b.c.rmem = rm; b.c.addr = a; b.c.wdata = wd;
    return b;
  endfunction

  function automatic beat_t cur_beat(input int p);
    if (p == 0) return mk(bus.m0_lock, bus.m0_wmem, bus.m0_rmem, bus.m0_addr, bus.m0_wdata);
    return mk(bus.m1_lock, bus.m1_wmem, bus.m1_rmem, bus.m1_addr, bus.m1_wdata);
  endfunction

  function automatic beat_t rnd_beat();
    logic [3:0] wm;
    logic [4:0] rm;
    case ($urandom_range(0, 6))
      0: wm = WM_SB0;   1: wm = WM_SB1;   2: wm = WM_SB2; 3: wm = WM_SB3;
      4: wm = WM_SH_LO; 5: wm = WM_SH_HI; default: wm = WM_SW;
    endcase
    case ($urandom_range(0, 12))
      0: rm = RM_LBU0;   1: rm = RM_LBU1;   2: rm = RM_LBU2;  3: rm = RM_LBU3;
      4: rm = RM_LB0;    5: rm = RM_LB1;    6: rm = RM_LB2;   7: rm = RM_LB3;
      8: rm = RM_LHU_LO; 9: rm = RM_LHU_HI; 10: rm = RM_LH_LO; 11: rm = RM_LH_HI;
      default: rm = RM_LW;
    endcase
    case ($urandom_range(0, 3))
      0: wm = 4'd0;
      1: rm = 5'd0;
      2: ;
      default: begin wm = 4'd0; rm = 5'd0; end
    endcase
    return mk($urandom_range(0, 2) == 0, wm, rm, 32'($urandom_range(0, 7)), $urandom);
  endfunction

  task automatic drive(input int p, input logic rq, input beat_t b);
    if (p == 0) begin
      bus.m0_req = rq; bus.m0_lock = b.lk; bus.m0_wmem = b.c.wmem;
      bus.m0_rmem = b.c.rmem; bus.m0_addr = b.c.addr; bus.m0_wdata = b.c.wdata;
    end else begin
      bus.m1_req = rq; bus.m1_lock = b.lk; bus.m1_wmem = b.c.wmem;
      bus.m1_rmem = b.c.rmem; bus.m1_addr = b.c.addr; bus.m1_wdata = b.c.wdata;
    end
  endtask

  // requesters hold a beat until granted, then take the next one from their queue
  task automatic tick();
    beat_t b;
    @(posedge clk); #1;
    if (!bus.m0_req || g_seen[0]) begin
      if (pq0.size() != 0) begin b = pq0.pop_front(); drive(0, 1'b1, b); end
      else drive(0, 1'b0, '0);
    end
    if (!bus.m1_req || g_seen[1]) begin
      if (pq1.size() != 0) begin b = pq1.pop_front(); drive(1, 1'b1, b); end
      else drive(1, 1'b0, '0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (pq0.size() != 0 || pq1.size() != 0 || bus.m0_req || bus.m1_req); i++) tick();
    repeat (4) tick();
  endtask

  // monitor (responses vs scoreboard) and reference model (grant + expected response)
  always @(negedge clk) begin
    logic [1:0] rq, eg;
    logic       rv;
    logic [31:0] rd;
    beat_t      b;
    rsp_t       e;
    int         w;
    g_seen  = {bus.m1_gnt, bus.m0_gnt};
    g1_hist = {g1_hist[6:0], bus.m1_gnt};
    if (!rst_n) begin
      sbq.delete();
      m_last = 1; m_active = 1'b0; m_run = 0;
      check("rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        rv = (p == 0) ? bus.m0_rvalid : bus.m1_rvalid;
        rd = (p == 0) ? bus.m0_rdata  : bus.m1_rdata;
        if (rv) begin
          rv_cnt[p]++;
          last_rd[p] = rd;
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: port %0d rvalid with rdata %h, expected no response", p, rd);
          end else begin
            e = sbq.pop_front();
            n_cmp--;
            check("rsp_port", 32'(p), 32'(e.port));
            check("rsp_data", rd, e.data);
            check("rsp_cycle", 32'(cyc), 32'(e.due));
          end
        end
      end
      rq = {bus.m1_req, bus.m0_req};
      if (m_active && rq[m_owner]) eg = (m_owner == 1) ? 2'b10 : 2'b01;
      else if (rq == 2'b11)        eg = (m_last == 1) ? 2'b01 : 2'b10;
      else                         eg = rq;
      check("gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'(eg));
      if (eg != 2'b00) begin
        w = eg[1] ? 1 : 0;
        b = cur_beat(w);
        sbq.push_back('{port: w, data: do_load(ref_mem[b.c.addr[5:0]], b.c.rmem), due: cyc + 2});
        if (b.c.wmem != 4'd0) ref_mem[b.c.addr[5:0]] = do_store(ref_mem[b.c.addr[5:0]], b.c.wmem, b.c.wdata);
        if (b.lk) begin
          if (m_active && m_owner == w) m_run++;
          else begin m_owner = w; m_run = 1; end
          m_active = (m_run < LOCK_MAX);
          if (!m_active) m_run = 0;
        end else begin
          m_active = 1'b0; m_run = 0;
        end
        m_last = w;
      end else begin
        m_active = 1'b0; m_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, saved;
    int r0, r1;
    for (int i = 0; i < 64; i++) begin v = $urandom; mem[i] = v; ref_mem[i] = v; end
    mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    last_rd[0] = '0; last_rd[1] = '0; rv_cnt[0] = 0; rv_cnt[1] = 0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",        32'({bus.m1_gnt, bus.m0_gnt}), 32'd0);
    check("rst_rvalid_out", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
    check("rst_rdata0",     bus.m0_rdata, 32'd0);
    check("rst_rdata1",     bus.m1_rdata, 32'd0);
    check("rst_wmem",       32'(bus.wmem), 32'd0);
    check("rst_rmem",       32'(bus.rmem), 32'd0);
    check("rst_mem_addr",   bus.mem_addr, 32'd0);
    check("rst_store_data", bus.store_data, 32'd0);
    rst_n = 1'b1;

    // both ports contend with no lock: 0,1,0,1
    pq0.push_back(mk(1'b0, 4'd0, RM_LW, 32'd1, 32'd0));
    pq0.push_back(mk(1'b0, 4'd0, RM_LW, 32'd3, 32'd0));
    pq1.push_back(mk(1'b0, 4'd0, RM_LW, 32'd2, 32'd0));
    pq1.push_back(mk(1'b0, 4'd0, RM_LW, 32'd4, 32'd0));
    repeat (4) tick();
    @(negedge clk); #1;
    check("rr_seq_m1gnt", 32'(g1_hist[3:0]), 32'b0101);
    drain();

    // single port 0 word load
    last_rd[0] = 32'd0;
    r1 = rv_cnt[1];
    pq0.push_back(mk(1'b0, 4'd0, RM_LW, 32'h10, 32'd0));
    repeat (5) tick();
    check("p0_load_data", last_rd[0], 32'hDEADBEEF);
    check("p1_no_rvalid", 32'(rv_cnt[1]), 32'(r1));
    drain();

    // lock bound: port 1 locks alone, port 0 joins next cycle -> 1,1,1,0,1
    for (int i = 0; i < 6; i++) pq1.push_back(mk(1'b1, 4'd0, RM_LW, 32'(i), 32'd0));
    tick();
    pq0.push_back(mk(1'b0, 4'd0, RM_LW, 32'd7, 32'd0));
    pq0.push_back(mk(1'b0, 4'd0, 5'd0, 32'd6, 32'd0));
    repeat (4) tick();
    @(negedge clk); #1;
    check("lock_seq_m1gnt", 32'(g1_hist[4:0]), 32'b11101);
    drain();

    // store byte then load the same byte back-to-back
    pq0.push_back(mk(1'b0, WM_SB2, 5'd0, 32'd4, 32'h0000_00A5));
    pq0.push_back(mk(1'b0, 4'd0, RM_LB2, 32'd4, 32'd0));
    repeat (6) tick();
    check("fwd_load_data", last_rd[0], 32'hFFFF_FFA5);
    drain();

    // reset while a store sits in the issue stage
    saved = ref_mem[8];
    r0 = rv_cnt[0];
    pq0.push_back(mk(1'b0, WM_SW, 5'd0, 32'd8, 32'h1234_5678));
    tick();
    @(negedge clk);
    @(posedge clk); #1;
    check("mid_wmem_issued", 32'(bus.wmem), 32'(WM_SW));
    drive(0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("mid_wmem_async", 32'(bus.wmem), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_mem_kept", mem[8], saved);
    ref_mem[8] = saved;
    rst_n = 1'b1;
    repeat (6) tick();
    check("mid_no_rvalid", 32'(rv_cnt[0]), 32'(r0));

    // idle: nothing moves
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", 32'({bus.wmem, bus.rmem, bus.m1_gnt, bus.m0_gnt, bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
    end

    // random traffic
    repeat (2000) begin
      if (pq0.size() < 2 && $urandom_range(0, 3) != 0) pq0.push_back(rnd_beat());
      if (pq1.size() < 2 && $urandom_range(0, 3) != 0) pq1.push_back(rnd_beat());
      tick();
    end
    drain();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory `dmem`. Port 0 carries the core's load/store unit; port 1 carries the debug/loader master that preloads and inspects data memory. The block selects one request per cycle using round-robin with an optional bounded lock, and registers the winning command into an issue stage that drives `dmem`. It captures `load_data` and returns a tagged response to the originating port.

## Interface
- `ADDR_W`, 32: word address width forwarded to `mem_addr`
- `DATA_W`, 32: data width
- `LOCK_MAX`, 8: maximum consecutive grants a locking port may hold; must be ≥ 1
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active low; one clock, no other clock domains
- `m0_req`, `m1_req`  in  1  request valid
- `m0_lock`, `m1_lock`  in  1  requester wants to keep the grant after this beat
- `m0_wmem`, `m1_wmem`  in  4  byte-lane store mask, `dmem` encoding
- `m0_rmem`, `m1_rmem`  in  5  load mask; bit 4 selects sign extension
- `m0_addr`, `m1_addr`  in  ADDR_W  word address
- `m0_wdata`, `m1_wdata`  in  DATA_W  store data, low-aligned
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle response pulse
- `m0_rdata`, `m1_rdata`  out  DATA_W  load result; 0 for stores
- `wmem`  out  4  to `dmem`
- `rmem`  out  5  to `dmem`
- `mem_addr`  out  ADDR_W  to `dmem`
- `store_data`  out  DATA_W  to `dmem`
- `load_data`  in  DATA_W  from `dmem`, combinational on `mem_addr`/`rmem`

## Operation
- A handshake completes when `mN_req && mN_gnt` are both high in the same cycle. `gnt` is a combinational function of the `req` inputs and registered state. Requesters hold their request fields stable until granted.
- Arbitration:
  - If only one port requests, it wins.
  - If both request, the port that was not granted last wins. The `last` pointer resets to 1, so port 0 wins the first tie.
  - At most one `gnt` is high per cycle.
- Lock:
  - A granted beat with `lock=1` enters LOCKED(owner). The owner then wins unconditionally while it requests.
  - `lock_cnt` counts granted beats in LOCKED. The lock releases when the owner's beat has `lock=0`, when the owner drops `req`, or when `lock_cnt` reaches `LOCK_MAX`.
  - A forced release hands priority to the other port if it is requesting, and `last` updates normally.
- FSM states: IDLE → LOCKED on a granted beat with `lock=1`. LOCKED → IDLE on any release condition. LOCKED → LOCKED otherwise. Reset enters IDLE.
- Issue stage:
  - The accepted beat is registered as `iss_v`, `iss_port`, `wmem`, `rmem`, `mem_addr`, `store_data`.
  - When `iss_v=0`, `wmem` and `rmem` are forced to 0, so idle cycles never write.
- Response stage:
  - In the cycle after issue, `rvalid` pulses on `iss_port`. `rdata` holds `load_data` registered from the issue cycle.
  - `rdata` is 0 when `rmem==0`, which covers stores and no-ops.
- A beat with both `wmem` and `rmem` equal to 0 is accepted and completes as a no-op with a response.
- A beat with both non-zero performs the store and returns the pre-store load value.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `wmem`=0, `rmem`=0, `mem_addr`=0, `store_data`=0, FSM=IDLE, `lock_cnt`=0, `last`=1.
- Latency: handshake in cycle N; the `dmem` command is driven in N+1, where the store commits at the end of N+1; `rvalid`/`rdata` appear in N+2.
- Throughput is one beat per cycle with no bubble. Back-to-back grants to the same or alternating ports are legal.
- A load issued in N+1 observes a store to the same address issued in N, because the store commits at the end of N.
- Asserting reset mid-operation discards the in-flight issue and response beats immediately (asynchronously). `wmem` drops to 0 within the same cycle, no `rvalid` is produced, and the lock is cleared.

## Structure
- Package `dmem_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults
  - `wmem` constants `WM_SB0..WM_SB3`, `WM_SH_LO`, `WM_SH_HI`, `WM_SW`
  - `rmem` constants `RM_LBU0..3`, `RM_LB0..3`, `RM_LHU_LO/HI`, `RM_LH_LO/HI`, `RM_LW`
  - the `arb_state_t` enum {IDLE, LOCKED}
  - the `dmem_cmd_t` struct {`wmem`, `rmem`, `addr`, `wdata`}
- Sub-module `rr_arb2` contains the two-requester round-robin plus lock owner and counter and outputs the one-hot grant. `dmem_arbiter` contains the mux, issue and response registers.

## Test plan
- Single port 0 load: `m0_rmem`=`RM_LW`, addr 0x10, with memory[0x10]=0xDEADBEEF → `m0_gnt` in N, `m0_rvalid` in N+2 with `rdata`=0xDEADBEEF; `m1_rvalid` stays 0.
- Simultaneous requests: both ports request for 4 cycles with no lock → grant sequence 0,1,0,1; responses return in the same order, 2 cycles later.
- Lock bound: `LOCK_MAX`=3, port 1 requests with `lock=1` continuously and port 0 requests continuously → grants 1,1,1,0, then port 1 may relock.
- Store then load forwarding: port 0 issues `WM_SB2`, wdata 0xA5, addr 4, then immediately `RM_LB2`, addr 4 → second `rdata`=0xFFFFFFA5.
- Reset mid-flight: assert `rst_n`=0 in the cycle after a store grant → `wmem` goes to 0 asynchronously, the memory word is unchanged, and no `rvalid` is seen.
- Idle: no requests for 10 cycles → `wmem`=0 and `rmem`=0 throughout, with no `gnt` and no `rvalid`.
